// File: rtl/adpll_ctrl_gear.sv
// adpll_ctrl_gear: parametrised ADPLL loop controller between PFD and DCO.
// Frequency acquisition uses a binary search with a halving step. Phase tracking
// then moves the code by +/-1 and includes a phase-lock detector based on direction flips.
// Optional feature macro: ADPLL_LOSS_OF_LOCK_EN. When defined, a long same-direction
// run in TRACK drops both locks and restarts the search from the current code.
module adpll_ctrl_gear #(
    parameter int CODE_W   = 5,
    parameter int LOCK_CNT = 4,
    parameter int LOL_CNT  = 8,
    parameter int CNT_W    = 4
) (
    input  logic              phase_clk,
    input  logic              reset,
    input  logic              p_up,
    input  logic              p_down,
    output logic [CODE_W-1:0] dco_code,
    output logic              freq_lock,
    output logic              phase_lock,
    output logic              polarity
);

    localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(2 ** (CODE_W - 1));
    localparam logic [CODE_W-1:0] STEP_INIT = CODE_W'(2 ** ((CODE_W >= 2) ? CODE_W - 2 : 0));
    localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
    localparam logic [CNT_W-1:0]  LOCK_LIM  = CNT_W'(LOCK_CNT);

    // This block appears in the elaborated hierarchy only when the counters cannot hold their limits.
    generate
        if (LOCK_CNT < 1 || LOCK_CNT > 2 ** CNT_W - 1 || LOL_CNT > 2 ** CNT_W - 1) begin : g_cnt_w_too_narrow
        end
    endgenerate

    typedef enum logic {SEARCH = 1'b0, TRACK = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [CODE_W-1:0] code_reg, code_next;
    logic [CODE_W-1:0] step_reg, step_next;
    logic              polarity_reg, polarity_next;
    logic              phase_lock_reg, phase_lock_next;
    logic [CNT_W-1:0]  flip_cnt_reg, flip_cnt_next;
`ifdef ADPLL_LOSS_OF_LOCK_EN
    localparam logic [CNT_W-1:0] LOL_LIM = CNT_W'(LOL_CNT);
    logic [CNT_W-1:0]  run_cnt_reg, run_cnt_next;
`endif

    logic              decision;
    logic [CODE_W-1:0] amount;
    logic [CODE_W:0]   raised;
    logic [CODE_W-1:0] moved_code;

    assign decision = p_up ^ p_down;

    // Saturating move of the code: by the search step in SEARCH, by 1 in TRACK.
    always_comb begin
        amount = (state_reg == SEARCH) ? step_reg : CODE_W'(1);
        raised = {1'b0, code_reg} + {1'b0, amount};
        if (p_up) begin
            moved_code = raised[CODE_W] ? CODE_MAX : raised[CODE_W-1:0];
        end else begin
            moved_code = (amount > code_reg) ? '0 : code_reg - amount;
        end
    end

    // State and datapath registers; reset overrides every decision.
    always_ff @(posedge phase_clk) begin
        if (reset) begin
            state_reg      <= SEARCH;
            code_reg       <= CODE_INIT;
            step_reg       <= STEP_INIT;
            polarity_reg   <= 1'b0;
            phase_lock_reg <= 1'b0;
            flip_cnt_reg   <= '0;
`ifdef ADPLL_LOSS_OF_LOCK_EN
            run_cnt_reg    <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            code_reg       <= code_next;
            step_reg       <= step_next;
            polarity_reg   <= polarity_next;
            phase_lock_reg <= phase_lock_next;
            flip_cnt_reg   <= flip_cnt_next;
`ifdef ADPLL_LOSS_OF_LOCK_EN
            run_cnt_reg    <= run_cnt_next;
`endif
        end
    end

    // Next-state logic: apply a valid decision and leave everything held otherwise.
    always_comb begin
        state_next      = state_reg;
        code_next       = code_reg;
        step_next       = step_reg;
        polarity_next   = polarity_reg;
        phase_lock_next = phase_lock_reg;
        flip_cnt_next   = flip_cnt_reg;
`ifdef ADPLL_LOSS_OF_LOCK_EN
        run_cnt_next    = run_cnt_reg;
`endif
        if (decision) begin
            code_next     = moved_code;
            polarity_next = p_up;
            if (state_reg == SEARCH) begin
                // The entry decision into TRACK does not touch the counters.
                step_next = step_reg >> 1;
                if (step_reg == CODE_W'(1)) begin
                    state_next = TRACK;
                end
            end else begin
                if (p_up != polarity_reg) begin
                    if (flip_cnt_reg < LOCK_LIM) begin
                        flip_cnt_next = flip_cnt_reg + CNT_W'(1);
                    end
`ifdef ADPLL_LOSS_OF_LOCK_EN
                    run_cnt_next = CNT_W'(1);
`endif
                end else begin
                    flip_cnt_next = '0;
`ifdef ADPLL_LOSS_OF_LOCK_EN
                    if (run_cnt_reg < LOL_LIM) begin
                        run_cnt_next = run_cnt_reg + CNT_W'(1);
                    end
`endif
                end
                // Phase lock is sticky once set.
                if (flip_cnt_next == LOCK_LIM) begin
                    phase_lock_next = 1'b1;
                end
`ifdef ADPLL_LOSS_OF_LOCK_EN
                // Long one-sided run: restart the search from the code just produced.
                if (run_cnt_next == LOL_LIM) begin
                    state_next      = SEARCH;
                    step_next       = STEP_INIT;
                    phase_lock_next = 1'b0;
                    flip_cnt_next   = '0;
                    run_cnt_next    = '0;
                end
`endif
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        dco_code   = code_reg;
        freq_lock  = (state_reg == TRACK);
        phase_lock = phase_lock_reg;
        polarity   = polarity_reg;
    end

endmodule

// File: tb/tb_adpll_ctrl_gear.sv
// tb_adpll_ctrl_gear: directed scenarios and randomized decisions, with a behavioural
// loop model used as the reference. Define ADPLL_LOSS_OF_LOCK_EN to test that build.
module tb_adpll_ctrl_gear;

    localparam int CW    = 5;
    localparam int LOCK  = 4;
    localparam int LOL   = 8;
    localparam int CMAX  = 31;
    localparam int CINIT = 16;
    localparam int SINIT = 8;

    logic          phase_clk = 1'b0;
    logic          reset     = 1'b1;
    logic          p_up      = 1'b0;
    logic          p_down    = 1'b0;
    logic [CW-1:0] dco_code;
    logic          freq_lock;
    logic          phase_lock;
    logic          polarity;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int m_code, m_step, m_flips, m_run;
    bit m_track, m_plock, m_pol;

    adpll_ctrl_gear #(.CODE_W(CW), .LOCK_CNT(LOCK), .LOL_CNT(LOL), .CNT_W(4)) dut (
        .phase_clk (phase_clk),
        .reset     (reset),
        .p_up      (p_up),
        .p_down    (p_down),
        .dco_code  (dco_code),
        .freq_lock (freq_lock),
        .phase_lock(phase_lock),
        .polarity  (polarity)
    );

    always #5 phase_clk = ~phase_clk;

    task automatic model_step(input bit rst, input bit up, input bit dn);
        if (rst) begin
            m_code = CINIT; m_step = SINIT; m_track = 0; m_plock = 0;
            m_pol = 0; m_flips = 0; m_run = 0;
        end else if (up != dn) begin
            if (!m_track) begin
                m_code = up ? m_code + m_step : m_code - m_step;
                m_pol  = up;
                if (m_step == 1) m_track = 1;
                m_step = m_step / 2;
            end else begin
                m_code = up ? m_code + 1 : m_code - 1;
                if (up != m_pol) begin
                    m_flips = (m_flips + 1 > LOCK) ? LOCK : m_flips + 1;
                    m_run   = 1;
                end else begin
                    m_flips = 0;
                    m_run   = m_run + 1;
                end
                m_pol = up;
                if (m_flips >= LOCK) m_plock = 1;
`ifdef ADPLL_LOSS_OF_LOCK_EN
                if (m_run >= LOL) begin
                    m_track = 0; m_step = SINIT; m_plock = 0; m_flips = 0; m_run = 0;
                end
`endif
            end
            if (m_code > CMAX) m_code = CMAX;
            if (m_code < 0) m_code = 0;
        end
    endtask

    // One phase comparison: drive, clock, advance the model, print the transaction.
    task automatic drive(input bit up, input bit dn);
        p_up   = up;
        p_down = dn;
        @(posedge phase_clk);
        #1;
        model_step(reset, up, dn);
        $display("edge rst=%0b up=%0b dn=%0b -> code=%0d freq_lock=%0b phase_lock=%0b polarity=%0b",
                 reset, up, dn, dco_code, freq_lock, phase_lock, polarity);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) drive(1'($urandom), 1'($urandom));
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(2);
        n_checks++;
        if (dco_code !== 5'd16 || freq_lock !== 1'b0 || phase_lock !== 1'b0 || polarity !== 1'b0)
            $display("FAIL reset_state: got code=%0d fl=%0b pl=%0b pol=%0b, want code=16 fl=0 pl=0 pol=0",
                     dco_code, freq_lock, phase_lock, polarity);
        else n_pass++;
    endtask

    task automatic test_acquire_and_lock();
        bit up_seq [8] = '{1, 1, 0, 1, 0, 1, 0, 1};
        int code_x [8] = '{24, 28, 26, 27, 26, 27, 26, 27};
        bit fl_x   [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        bit pl_x   [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        apply_reset(1);
        for (int i = 0; i < 8; i++) begin
            drive(up_seq[i], !up_seq[i]);
            n_checks++;
            if (dco_code !== 5'(code_x[i]) || freq_lock !== fl_x[i] || phase_lock !== pl_x[i] ||
                polarity !== up_seq[i])
                $display("FAIL acquire_lock[%0d]: got code=%0d fl=%0b pl=%0b pol=%0b, want code=%0d fl=%0b pl=%0b pol=%0b",
                         i, dco_code, freq_lock, phase_lock, polarity, code_x[i], fl_x[i], pl_x[i], up_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        int up_x [6] = '{24, 28, 30, 31, 31, 31};
        int dn_x [6] = '{8, 4, 2, 1, 0, 0};
        apply_reset(1);
        for (int i = 0; i < 6; i++) begin
            drive(1, 0);
            n_checks++;
            if (dco_code !== 5'(up_x[i]) || freq_lock !== (i >= 3))
                $display("FAIL saturate_high[%0d]: got code=%0d fl=%0b, want code=%0d fl=%0b",
                         i, dco_code, freq_lock, up_x[i], (i >= 3));
            else n_pass++;
        end
        apply_reset(1);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1);
            n_checks++;
            if (dco_code !== 5'(dn_x[i]) || freq_lock !== (i >= 3) || polarity !== 1'b0)
                $display("FAIL saturate_low[%0d]: got code=%0d fl=%0b pol=%0b, want code=%0d fl=%0b pol=0",
                         i, dco_code, freq_lock, polarity, dn_x[i], (i >= 3));
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [CW-1:0] code_s;
        logic          fl_s, pl_s, pol_s;
        apply_reset(1);
        drive(1, 0);
        for (int phase = 0; phase < 2; phase++) begin
            code_s = dco_code; fl_s = freq_lock; pl_s = phase_lock; pol_s = polarity;
            for (int i = 0; i < 3; i++) begin
                drive(i[0], i[0]);
                n_checks++;
                if (dco_code !== code_s || freq_lock !== fl_s || phase_lock !== pl_s || polarity !== pol_s)
                    $display("FAIL hold[%0d.%0d]: got code=%0d fl=%0b pl=%0b pol=%0b, want code=%0d fl=%0b pl=%0b pol=%0b",
                             phase, i, dco_code, freq_lock, phase_lock, polarity, code_s, fl_s, pl_s, pol_s);
                else n_pass++;
            end
            // Held step must still be 4 in SEARCH: 24 -> 28.
            if (phase == 0) begin
                drive(1, 0);
                n_checks++;
                if (dco_code !== 5'd28)
                    $display("FAIL hold_step: got code=%0d, want 28", dco_code);
                else n_pass++;
                drive(0, 1);
                drive(1, 0);
            end
        end
        drive(0, 1);
        n_checks++;
        if (dco_code !== 5'd26 || freq_lock !== 1'b1)
            $display("FAIL hold_track_resume: got code=%0d fl=%0b, want code=26 fl=1", dco_code, freq_lock);
        else n_pass++;
    endtask

    task automatic test_loss_of_lock();
        bit up_seq [8] = '{1, 1, 0, 1, 0, 1, 0, 1};
        bit fl_end, pl_end;
        int code_after;
`ifdef ADPLL_LOSS_OF_LOCK_EN
        fl_end = 0; pl_end = 0; code_after = 27;
`else
        fl_end = 1; pl_end = 1; code_after = 20;
`endif
        apply_reset(1);
        for (int i = 0; i < 8; i++) drive(up_seq[i], !up_seq[i]);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1);
            n_checks++;
            if (dco_code !== 5'(26 - i) || freq_lock !== ((i == 7) ? fl_end : 1'b1) ||
                phase_lock !== ((i == 7) ? pl_end : 1'b1))
                $display("FAIL down_run[%0d]: got code=%0d fl=%0b pl=%0b, want code=%0d fl=%0b pl=%0b",
                         i, dco_code, freq_lock, phase_lock, 26 - i,
                         (i == 7) ? fl_end : 1'b1, (i == 7) ? pl_end : 1'b1);
            else n_pass++;
        end
        drive(1, 0);
        n_checks++;
        if (dco_code !== 5'(code_after) || freq_lock !== fl_end)
            $display("FAIL after_run: got code=%0d fl=%0b, want code=%0d fl=%0b",
                     dco_code, freq_lock, code_after, fl_end);
        else n_pass++;
    endtask

    task automatic test_reset_mid_search();
        apply_reset(1);
        drive(1, 0);
        drive(1, 0);
        reset = 1'b1;
        drive(1, 0);
        reset = 1'b0;
        n_checks++;
        if (dco_code !== 5'd16 || freq_lock !== 1'b0 || phase_lock !== 1'b0 || polarity !== 1'b0)
            $display("FAIL reset_mid_search: got code=%0d fl=%0b pl=%0b pol=%0b, want code=16 fl=0 pl=0 pol=0",
                     dco_code, freq_lock, phase_lock, polarity);
        else n_pass++;
        drive(1, 0);
        n_checks++;
        if (dco_code !== 5'd24 || freq_lock !== 1'b0)
            $display("FAIL search_restart: got code=%0d fl=%0b, want code=24 fl=0", dco_code, freq_lock);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        bit up, dn;
        for (int round = 0; round < 4; round++) begin
            apply_reset(1);
            for (int i = 0; i < 150; i++) begin
                r = int'($urandom_range(0, 99));
                reset = (r < 2);
                if (r < 12) begin
                    up = r[0]; dn = r[0];
                end else begin
                    up = 1'($urandom); dn = !up;
                end
                drive(up, dn);
                n_checks++;
                if (dco_code !== 5'(m_code) || freq_lock !== m_track || phase_lock !== m_plock ||
                    polarity !== m_pol)
                    $display("FAIL random[%0d.%0d]: got code=%0d fl=%0b pl=%0b pol=%0b, want code=%0d fl=%0b pl=%0b pol=%0b",
                             round, i, dco_code, freq_lock, phase_lock, polarity,
                             m_code, m_track, m_plock, m_pol);
                else n_pass++;
            end
            reset = 1'b0;
        end
    endtask

    initial begin
        model_step(1, 0, 0);
        test_reset();
        test_acquire_and_lock();
        test_saturate();
        test_hold();
        test_loss_of_lock();
        test_reset_mid_search();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
